// File: rtl/rvc_fetch_align.sv
// Instruction fetch and halfword realignment buffer feeding the decode stage.
// Compressed (RVC) instruction support is compiled in when RVC_FETCH_EN is defined.
module rvc_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 4
) (
    input  logic        clk_sc,
    input  logic        reset,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_gnt,
    input  logic        fetch_rvalid,
    input  logic [31:0] fetch_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_is_c,
    output logic        instr_err
);

    localparam int BW = 16 * BUF_HW;

    // Slot 0 (bits 15:0) is the oldest halfword; slots at or above count are kept zero.
    logic [BW-1:0] buf_q, buf_d, shifted;
    logic [2:0]    count_q, count_d, base;
    logic [1:0]    pop_hw, app_hw;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;
    logic          skip_q, skip_d;
    logic          req_d;
    logic [31:0]   addr_d, pc_d, app_data;
    logic [15:0]   head_lo, head_hi;
    logic          head_is_32, pop, gnt_now, rsp_now, append;

    assign head_lo = buf_q[15:0];
    assign head_hi = buf_q[31:16];

`ifdef RVC_FETCH_EN
    assign head_is_32 = (head_lo[1:0] == 2'b11);
    assign instr_err  = 1'b0;
`else
    logic err_pend_q, err_pend_d;

    assign head_is_32 = 1'b1;
    assign instr_err  = instr_valid && ((head_lo[1:0] != 2'b11) || err_pend_q);
`endif

    assign instr_valid = head_is_32 ? (count_q >= 3'd2) : (count_q >= 3'd1);
    assign instr_is_c  = instr_valid && !head_is_32;
    assign instr_out   = !instr_valid ? 32'h0 :
                         head_is_32   ? {head_hi, head_lo} : {16'h0, head_lo};

    always_comb begin
        pop      = instr_valid && instr_ready && !redirect_valid;
        pop_hw   = pop ? (head_is_32 ? 2'd2 : 2'd1) : 2'd0;
        gnt_now  = fetch_req && fetch_gnt;
        rsp_now  = outstanding_q && fetch_rvalid;
        append   = rsp_now && !discard_q && !redirect_valid;
        app_hw   = append ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
        app_data = skip_q ? {16'h0, fetch_rdata[31:16]} : fetch_rdata;
        base     = count_q - {1'b0, pop_hw};
        shifted  = buf_q >> {pop_hw, 4'b0000};
        buf_d    = shifted;
        if (append)
            buf_d = shifted | ({{(BW-32){1'b0}}, app_data} << {base, 4'b0000});
        count_d  = base + {1'b0, app_hw};

        // A response still in flight after a redirect belongs to the old stream.
        outstanding_d = gnt_now || (outstanding_q && !rsp_now);
        discard_d     = discard_q && !rsp_now;
        skip_d        = append ? 1'b0 : skip_q;
        addr_d        = gnt_now ? fetch_addr + 32'd4 : fetch_addr;
        pc_d          = instr_pc + {29'd0, pop_hw, 1'b0};

        if (redirect_valid) begin
            buf_d     = '0;
            count_d   = 3'd0;
            discard_d = outstanding_d;
            skip_d    = redirect_pc[1];
            addr_d    = {redirect_pc[31:2], 2'b00};
            pc_d      = redirect_pc;
        end

        req_d = !outstanding_d && (count_d <= 3'd2);
    end

`ifndef RVC_FETCH_EN
    // Without RVC a halfword-odd target cannot be a legal instruction start.
    always_comb begin
        err_pend_d = err_pend_q;
        if (redirect_valid)
            err_pend_d = redirect_pc[1];
        else if (pop)
            err_pend_d = 1'b0;
    end

    always_ff @(posedge clk_sc or posedge reset) begin
        if (reset)
            err_pend_q <= RESET_PC[1];
        else
            err_pend_q <= err_pend_d;
    end
`endif

    always_ff @(posedge clk_sc or posedge reset) begin
        if (reset) begin
            buf_q         <= '0;
            count_q       <= 3'd0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            skip_q        <= RESET_PC[1];
            fetch_req     <= 1'b0;
            fetch_addr    <= {RESET_PC[31:2], 2'b00};
            instr_pc      <= RESET_PC;
        end else begin
            buf_q         <= buf_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            skip_q        <= skip_d;
            fetch_req     <= req_d;
            fetch_addr    <= addr_d;
            instr_pc      <= pc_d;
        end
    end

endmodule
